// File: rtl/dpsram_pkg.sv
// Shared definitions for the parametrised dual-port SRAM buffer.
// Contains the clear-FSM state encoding and the memory model settle delay used by benches.
package dpsram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Settle time after a clock edge before a bench samples array outputs.
  localparam int TDLY_MEM = 1;

endpackage

// File: rtl/dpsram_param_buf_if.sv
// Bus bundle for both access ports plus the status outputs of dpsram_param_buf.
// The slave modport is the buffer side; master is the requester side.
interface dpsram_param_buf_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
);
  logic              i_EN_R_A;
  logic              i_EN_W_A;
  logic [ADDR_W-1:0] i_Addr_A;
  logic [DATA_W-1:0] i_DataIn_A;
  logic [DATA_W-1:0] o_DataOut_A;
  logic              o_Valid_A;

  logic              i_EN_R_B;
  logic              i_EN_W_B;
  logic [ADDR_W-1:0] i_Addr_B;
  logic [DATA_W-1:0] i_DataIn_B;
  logic [DATA_W-1:0] o_DataOut_B;
  logic              o_Valid_B;

  logic              o_Ready;
  logic              o_Collision;

  modport slave (
    input  i_EN_R_A, i_EN_W_A, i_Addr_A, i_DataIn_A,
    input  i_EN_R_B, i_EN_W_B, i_Addr_B, i_DataIn_B,
    output o_DataOut_A, o_Valid_A, o_DataOut_B, o_Valid_B,
    output o_Ready, o_Collision
  );

  modport master (
    output i_EN_R_A, i_EN_W_A, i_Addr_A, i_DataIn_A,
    output i_EN_R_B, i_EN_W_B, i_Addr_B, i_DataIn_B,
    input  o_DataOut_A, o_Valid_A, o_DataOut_B, o_Valid_B,
    input  o_Ready, o_Collision
  );
endinterface

// File: rtl/dpsram_core.sv
// Behavioural DEPTH x DATA_W array with two write ports and registered reads.
// Reads return the pre-write contents; the top level supplies any forwarding. Replaceable by a macro.
module dpsram_core #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              i_weA,
  input  logic              i_reA,
  input  logic [ADDR_W-1:0] i_addrA,
  input  logic [DATA_W-1:0] i_dinA,
  output logic [DATA_W-1:0] o_doutA,
  input  logic              i_weB,
  input  logic              i_reB,
  input  logic [ADDR_W-1:0] i_addrB,
  input  logic [DATA_W-1:0] i_dinB,
  output logic [DATA_W-1:0] o_doutB
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_doutA;
  logic [DATA_W-1:0] r_doutB;

  // Callers never enable both writes to the same address in one cycle.
  always_ff @(posedge CLK) begin
    if (i_weA) r_mem[i_addrA] <= i_dinA;
    if (i_weB) r_mem[i_addrB] <= i_dinB;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_doutA <= '0;
      r_doutB <= '0;
    end else begin
      if (i_reA) r_doutA <= r_mem[i_addrA];
      if (i_reB) r_doutB <= r_mem[i_addrB];
    end
  end

  assign o_doutA = r_doutA;
  assign o_doutB = r_doutB;

endmodule

// File: rtl/dpsram_param_buf.sv
// True dual-port SRAM buffer: post-reset clear FSM, same-address arbitration,
// write-first forwarding and read-valid/output pipelines around dpsram_core.
module dpsram_param_buf
  import dpsram_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int OUT_REG = 0,
  parameter int CLR_EN  = 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  dpsram_param_buf_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              w_clearing;
  logic [ADDR_W-1:0] r_clrAddr;
  logic              r_ready;

  logic              w_rdA, w_wrA, w_rdB, w_wrB, w_wrBKeep;
  logic              w_addrEq, w_coll;
  logic              w_fwdA, w_fwdB;
  logic [DATA_W-1:0] w_fwdDataA, w_fwdDataB;

  logic              w_coreWeA;
  logic [ADDR_W-1:0] w_coreAddrA;
  logic [DATA_W-1:0] w_coreDinA;
  logic [DATA_W-1:0] w_coreDoutA, w_coreDoutB;

  logic              r_vldA1, r_vldB1;
  logic              r_fwdA, r_fwdB;
  logic [DATA_W-1:0] r_fwdDataA, r_fwdDataB;
  logic [DATA_W-1:0] w_dataA1, w_dataB1;
  logic              r_coll;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= (CLR_EN != 0) ? ST_CLEAR : ST_IDLE;
      r_clrAddr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == ST_IDLE);
      if (r_state == ST_CLEAR) r_clrAddr <= r_clrAddr + 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_clearing  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clearing = 1'b1;
        if (r_clrAddr == LAST_ADDR) w_nextState = ST_IDLE;
      end
      ST_IDLE: w_nextState = ST_IDLE;
    endcase
  end

  assign w_rdA    = r_ready & bus.i_EN_R_A;
  assign w_wrA    = r_ready & bus.i_EN_W_A;
  assign w_rdB    = r_ready & bus.i_EN_R_B;
  assign w_wrB    = r_ready & bus.i_EN_W_B;
  assign w_addrEq = (bus.i_Addr_A == bus.i_Addr_B);

  // Port A wins a same-address double write, so B's write never reaches the array.
  assign w_wrBKeep = w_wrB & ~(w_wrA & w_addrEq);

  assign w_coll = w_addrEq & ((w_wrA & (w_rdB | w_wrB)) | (w_wrB & (w_rdA | w_wrA)));

  assign w_fwdA     = w_wrA | (w_wrB & w_addrEq);
  assign w_fwdDataA = w_wrA ? bus.i_DataIn_A : bus.i_DataIn_B;
  assign w_fwdB     = w_wrB | (w_wrA & w_addrEq);
  assign w_fwdDataB = (w_wrA & w_addrEq) ? bus.i_DataIn_A : bus.i_DataIn_B;

  assign w_coreWeA   = w_clearing | w_wrA;
  assign w_coreAddrA = w_clearing ? r_clrAddr : bus.i_Addr_A;
  assign w_coreDinA  = w_clearing ? '0 : bus.i_DataIn_A;

  dpsram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_weA   (w_coreWeA),
    .i_reA   (w_rdA),
    .i_addrA (w_coreAddrA),
    .i_dinA  (w_coreDinA),
    .o_doutA (w_coreDoutA),
    .i_weB   (w_wrBKeep),
    .i_reB   (w_rdB),
    .i_addrB (bus.i_Addr_B),
    .i_dinB  (bus.i_DataIn_B),
    .o_doutB (w_coreDoutB)
  );

  // Forward state only updates on accepted reads so the read data holds between reads.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_vldA1    <= 1'b0;
      r_vldB1    <= 1'b0;
      r_fwdA     <= 1'b0;
      r_fwdB     <= 1'b0;
      r_fwdDataA <= '0;
      r_fwdDataB <= '0;
      r_coll     <= 1'b0;
    end else begin
      r_vldA1 <= w_rdA;
      r_vldB1 <= w_rdB;
      r_coll  <= w_coll;
      if (w_rdA) begin
        r_fwdA     <= w_fwdA;
        r_fwdDataA <= w_fwdDataA;
      end
      if (w_rdB) begin
        r_fwdB     <= w_fwdB;
        r_fwdDataB <= w_fwdDataB;
      end
    end
  end

  assign w_dataA1 = r_fwdA ? r_fwdDataA : w_coreDoutA;
  assign w_dataB1 = r_fwdB ? r_fwdDataB : w_coreDoutB;

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic              r_vldA2, r_vldB2;
      logic [DATA_W-1:0] r_dataA2, r_dataB2;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          r_vldA2  <= 1'b0;
          r_vldB2  <= 1'b0;
          r_dataA2 <= '0;
          r_dataB2 <= '0;
        end else begin
          r_vldA2 <= r_vldA1;
          r_vldB2 <= r_vldB1;
          if (r_vldA1) r_dataA2 <= w_dataA1;
          if (r_vldB1) r_dataB2 <= w_dataB1;
        end
      end

      assign bus.o_DataOut_A = r_dataA2;
      assign bus.o_Valid_A   = r_vldA2;
      assign bus.o_DataOut_B = r_dataB2;
      assign bus.o_Valid_B   = r_vldB2;
    end else begin : g_noOutReg
      assign bus.o_DataOut_A = w_dataA1;
      assign bus.o_Valid_A   = r_vldA1;
      assign bus.o_DataOut_B = w_dataB1;
      assign bus.o_Valid_B   = r_vldB1;
    end
  endgenerate

  assign bus.o_Ready     = r_ready;
  assign bus.o_Collision = r_coll;

endmodule

// File: tb/tb_dpsram_param_buf.sv
// Directed bench for dpsram_param_buf: dut0 without and dut1 with the output register stage.
// Each scenario task drives its own vectors and checks against hand-computed values.
module tb_dpsram_param_buf;
  import dpsram_pkg::*;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  dpsram_param_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  dpsram_param_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  dpsram_param_buf #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(0), .CLR_EN(1)
  ) dut0 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus0)
  );

  dpsram_param_buf #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(1), .CLR_EN(1)
  ) dut1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus1)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #(TDLY_MEM);
  endtask

  task automatic idleInputs();
    bus0.i_EN_R_A = 1'b0; bus0.i_EN_W_A = 1'b0; bus0.i_Addr_A = '0; bus0.i_DataIn_A = '0;
    bus0.i_EN_R_B = 1'b0; bus0.i_EN_W_B = 1'b0; bus0.i_Addr_B = '0; bus0.i_DataIn_B = '0;
    bus1.i_EN_R_A = 1'b0; bus1.i_EN_W_A = 1'b0; bus1.i_Addr_A = '0; bus1.i_DataIn_A = '0;
    bus1.i_EN_R_B = 1'b0; bus1.i_EN_W_B = 1'b0; bus1.i_Addr_B = '0; bus1.i_DataIn_B = '0;
  endtask

  task automatic test_reset();
    int   cycles;
    logic sawValid;
    cycles   = 0;
    sawValid = 1'b0;
    idleInputs();
    RSTn = 1'b0;
    #12;
    nChecks++;
    if ({bus0.o_Ready, bus0.o_Valid_A, bus0.o_Valid_B, bus0.o_Collision} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus0.o_Ready, bus0.o_Valid_A, bus0.o_Valid_B, bus0.o_Collision});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    // A request issued mid-clear must be ignored entirely.
    while (!bus0.o_Ready && cycles < DEPTH + 50) begin
      if (cycles == 300) begin
        bus0.i_EN_W_A = 1'b1; bus0.i_Addr_A = 9'h005; bus0.i_DataIn_A = 24'h555555;
        bus0.i_EN_R_B = 1'b1; bus0.i_Addr_B = 9'h005;
      end else begin
        idleInputs();
      end
      tick();
      cycles++;
      if (bus0.o_Valid_B) sawValid = 1'b1;
    end
    idleInputs();
    nChecks++;
    if (cycles !== DEPTH) begin
      nFails++;
      $display("[TB] FAIL ready_latency: got %0d cycles expected %0d", cycles, DEPTH);
    end
    nChecks++;
    if (bus1.o_Ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL ready_outreg: got %b expected 1", bus1.o_Ready);
    end
    nChecks++;
    if (sawValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL valid_during_clear: got %b expected 0", sawValid);
    end
    bus0.i_EN_R_A = 1'b1; bus0.i_Addr_A = 9'h1FF;
    tick();
    nChecks++;
    if (bus0.o_Valid_A !== 1'b1 || bus0.o_DataOut_A !== 24'h0) begin
      nFails++;
      $display("[TB] FAIL read_1ff: got valid=%b data=%h expected valid=1 data=000000",
               bus0.o_Valid_A, bus0.o_DataOut_A);
    end
    bus0.i_Addr_A = 9'h005;
    tick();
    nChecks++;
    if (bus0.o_DataOut_A !== 24'h0) begin
      nFails++;
      $display("[TB] FAIL ignored_write: got %h expected 000000", bus0.o_DataOut_A);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_write_then_read();
    bus0.i_EN_W_A = 1'b1; bus0.i_Addr_A = 9'h010; bus0.i_DataIn_A = 24'hABCDEF;
    tick();
    nChecks++;
    if (bus0.o_Valid_B !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL valid_after_write: got %b expected 0", bus0.o_Valid_B);
    end
    idleInputs();
    bus0.i_EN_R_B = 1'b1; bus0.i_Addr_B = 9'h010;
    tick();
    nChecks++;
    if (bus0.o_Valid_B !== 1'b1 || bus0.o_DataOut_B !== 24'hABCDEF) begin
      nFails++;
      $display("[TB] FAIL read_b_010: got valid=%b data=%h expected valid=1 data=abcdef",
               bus0.o_Valid_B, bus0.o_DataOut_B);
    end
    idleInputs();
    tick();
    nChecks++;
    if (bus0.o_Valid_B !== 1'b0 || bus0.o_DataOut_B !== 24'hABCDEF) begin
      nFails++;
      $display("[TB] FAIL hold_b: got valid=%b data=%h expected valid=0 data=abcdef",
               bus0.o_Valid_B, bus0.o_DataOut_B);
    end
  endtask

  task automatic test_collision_forward();
    bus0.i_EN_W_A = 1'b1; bus0.i_Addr_A = 9'h020; bus0.i_DataIn_A = 24'h123456;
    bus0.i_EN_R_B = 1'b1; bus0.i_Addr_B = 9'h020;
    tick();
    nChecks++;
    if (bus0.o_DataOut_B !== 24'h123456 || bus0.o_Collision !== 1'b1 || bus0.o_Valid_A !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL fwd_a_to_b: got data=%h coll=%b validA=%b expected 123456 1 0",
               bus0.o_DataOut_B, bus0.o_Collision, bus0.o_Valid_A);
    end
    idleInputs();
    bus0.i_EN_W_B = 1'b1; bus0.i_Addr_B = 9'h024; bus0.i_DataIn_B = 24'h654321;
    bus0.i_EN_R_A = 1'b1; bus0.i_Addr_A = 9'h024;
    tick();
    nChecks++;
    if (bus0.o_DataOut_A !== 24'h654321 || bus0.o_Collision !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL fwd_b_to_a: got data=%h coll=%b expected 654321 1",
               bus0.o_DataOut_A, bus0.o_Collision);
    end
    idleInputs();
    bus0.i_EN_W_A = 1'b1; bus0.i_EN_R_A = 1'b1; bus0.i_Addr_A = 9'h040; bus0.i_DataIn_A = 24'h0BEEF0;
    tick();
    nChecks++;
    if (bus0.o_DataOut_A !== 24'h0BEEF0 || bus0.o_Collision !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL write_first_a: got data=%h coll=%b expected 0beef0 0",
               bus0.o_DataOut_A, bus0.o_Collision);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_double_write();
    bus0.i_EN_W_A = 1'b1; bus0.i_Addr_A = 9'h030; bus0.i_DataIn_A = 24'h111111;
    bus0.i_EN_W_B = 1'b1; bus0.i_Addr_B = 9'h030; bus0.i_DataIn_B = 24'h222222;
    tick();
    nChecks++;
    if (bus0.o_Collision !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL coll_double_write: got %b expected 1", bus0.o_Collision);
    end
    idleInputs();
    bus0.i_EN_R_A = 1'b1; bus0.i_Addr_A = 9'h030;
    bus0.i_EN_R_B = 1'b1; bus0.i_Addr_B = 9'h030;
    tick();
    nChecks++;
    if (bus0.o_DataOut_A !== 24'h111111 || bus0.o_DataOut_B !== 24'h111111 || bus0.o_Collision !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL a_wins: got A=%h B=%h coll=%b expected 111111 111111 0",
               bus0.o_DataOut_A, bus0.o_DataOut_B, bus0.o_Collision);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_back_to_back_outreg();
    bus1.i_EN_W_A = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus1.i_Addr_A = ADDR_W'(i);
      bus1.i_DataIn_A = 24'hA00000 + DATA_W'(i);
      tick();
    end
    idleInputs();
    bus1.i_EN_R_A = 1'b1; bus1.i_Addr_A = 9'h001;
    tick();
    nChecks++;
    if (bus1.o_Valid_A !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL outreg_lat1: got valid=%b expected 0", bus1.o_Valid_A);
    end
    for (int i = 2; i <= 4; i++) begin
      if (i <= 3) bus1.i_Addr_A = ADDR_W'(i);
      else idleInputs();
      tick();
      nChecks++;
      if (bus1.o_Valid_A !== 1'b1 || bus1.o_DataOut_A !== 24'hA00000 + DATA_W'(i - 1)) begin
        nFails++;
        $display("[TB] FAIL outreg_read%0d: got valid=%b data=%h expected valid=1 data=%h",
                 i - 1, bus1.o_Valid_A, bus1.o_DataOut_A, 24'hA00000 + DATA_W'(i - 1));
      end
    end
    tick();
    nChecks++;
    if (bus1.o_Valid_A !== 1'b0 || bus1.o_DataOut_A !== 24'hA00003) begin
      nFails++;
      $display("[TB] FAIL outreg_hold: got valid=%b data=%h expected valid=0 data=a00003",
               bus1.o_Valid_A, bus1.o_DataOut_A);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cycles;
    cycles = 0;
    RSTn = 1'b0;
    #1;
    nChecks++;
    if (bus0.o_Ready !== 1'b0 || bus0.o_DataOut_A !== 24'h0 || bus1.o_DataOut_A !== 24'h0) begin
      nFails++;
      $display("[TB] FAIL async_reset: got ready=%b A0=%h A1=%h expected 0 000000 000000",
               bus0.o_Ready, bus0.o_DataOut_A, bus1.o_DataOut_A);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (100) tick();
    #2;
    RSTn = 1'b0;
    #1;
    nChecks++;
    if ({bus0.o_Ready, bus0.o_Valid_A, bus0.o_Collision} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL mid_clear_reset: got %b expected 000",
               {bus0.o_Ready, bus0.o_Valid_A, bus0.o_Collision});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    while (!bus0.o_Ready && cycles < DEPTH + 50) begin
      tick();
      cycles++;
    end
    nChecks++;
    if (cycles !== DEPTH) begin
      nFails++;
      $display("[TB] FAIL restart_latency: got %0d cycles expected %0d", cycles, DEPTH);
    end
    bus0.i_EN_R_A = 1'b1; bus0.i_Addr_A = 9'h020;
    tick();
    nChecks++;
    if (bus0.o_Valid_A !== 1'b1 || bus0.o_DataOut_A !== 24'h0) begin
      nFails++;
      $display("[TB] FAIL cleared_020: got valid=%b data=%h expected valid=1 data=000000",
               bus0.o_Valid_A, bus0.o_DataOut_A);
    end
    idleInputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_collision_forward();
    test_double_write();
    test_back_to_back_outreg();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "[TB] timeout");
  end

endmodule
